mul_ctrl: RTL
=============

// Module: mul_ctrl
// PURPOSE
//  Issue/retire sequencer directly upstream of mul in the execute stage.
//  - Accepts M-extension multiply requests over a valid/ready handshake and registers the operands.
//  - Drives mul_in with a one-cycle enable pulse and holds operands stable until mul_out.ready.
//  - Captures the result and holds it in a 1-entry buffer until writeback takes it.
//  - Works with mul in either PERFORMANCE mode: single-cycle or 33-cycle serial.
// PARAMETERS
//  TIMEOUT  63  cycles in BUSY/DRAIN without mul_out.ready before err pulses; counter width $clog2(TIMEOUT+1)
// PORTS
//  clock      in   1    system clock, rising edge
//  reset      in   1    asynchronous, active-high
//  req_valid  in   1    request present
//  req_ready  out  1    controller can accept a request
//  req_rdata1 in   32   operand 1
//  req_rdata2 in   32   operand 2
//  req_op     in   mul_op_type  muls/mulh/mulhsu/mulhu one-hot
//  req_waddr  in   5    destination register
//  flush      in   1    squash the in-flight op (branch/exception)
//  mul_in     out  mul_in_type   to mul: rdata1, rdata2, op, enable
//  mul_out    in   mul_out_type  from mul: result, ready
//  res_valid  out  1    result buffer full
//  res_ready  in   1    writeback consumes the result
//  res_data   out  32   result
//  res_waddr  out  5    destination register
//  err        out  1    1-cycle pulse on timeout
// BEHAVIOUR
//  Reset (async): state=IDLE; req_ready=1; res_valid=0; res_data=0; res_waddr=0; err=0; mul_in all 0; timeout counter=0.
//  FSM states:
//  - IDLE: req_ready=1. On req_valid: latch operands, op and waddr; go to LAUNCH.
//  - LAUNCH: mul_in.enable=1 for exactly this cycle; go to BUSY, or straight to FULL if mul_out.ready is seen this cycle (fast mul).
//  - BUSY: enable=0; operands held. On mul_out.ready: res_data<=mul_out.result; go to FULL.
//  - FULL: res_valid=1, req_ready=0. On res_ready: go to IDLE.
//  - DRAIN: request already squashed. Wait for mul_out.ready, discard the result, go to IDLE.
//  Latency from request accept at T:
//  - PERFORMANCE=1 mul: res_valid at T+2.
//  - Serial mul: res_valid is 1 cycle after mul_out.ready (T+35).
//  Handshake rules:
//  - req_ready is 1 only in IDLE; no same-cycle accept in FULL.
//  - res_data and res_waddr stay stable while res_valid=1 && !res_ready.
//  Flush:
//  - IDLE: flush blocks acceptance; no request is taken that cycle.
//  - LAUNCH/BUSY with ready not seen that cycle: go to DRAIN (serial mul must not be re-enabled mid-op).
//  - LAUNCH/BUSY with ready seen: go to IDLE.
//  - FULL: res_valid drops next cycle; go to IDLE.
//  - flush and res_ready in the same cycle: flush wins, nothing retires.
//  Timeout:
//  - Counter clears on entry to LAUNCH/DRAIN and increments each BUSY/DRAIN cycle.
//  - At TIMEOUT: err=1 for one cycle, go to IDLE, result dropped.
//  Width rules: no arithmetic other than the counter; operands pass unmodified to mul (mul does sign handling).
// CONFIGURATION
//  MUL_REUSE_EN defined:
//  - Keep a last-result cache: {rdata1, rdata2, op, result, cvalid}, updated on every capture from mul.
//  - An IDLE request matching the cache exactly goes straight to FULL with the cached result; latency 1, mul_in.enable never asserts.
//  - cvalid clears on reset and on any flush.
//  MUL_REUSE_EN undefined: no cache logic; every request goes through LAUNCH.
// STRUCTURE
//  wires package gains:
//  - mul_ctrl_state_type enum {IDLE, LAUNCH, BUSY, FULL, DRAIN}
//  - mul_ctrl_reg_type and init_mul_ctrl_reg constant
//  Single two-process module (comb v/rin, always_ff r); no sub-module.
//  mul is instantiated beside it in the execute stage, not inside it.
// TESTING
//  Fast mul, muls 7*-3, res_ready=1 -> res_valid at T+2, res_data=0xFFFFFFEB, one enable pulse.
//  Serial mul, mulhu 0xFFFFFFFF*0xFFFFFFFF -> res_data=0xFFFFFFFE one cycle after mul_out.ready; req_ready=0 throughout.
//  res_ready held 0 for 5 cycles in FULL -> res_data/res_waddr stable, second req_valid not accepted until retire.
//  Serial mul, flush 10 cycles after launch -> DRAIN, no res_valid, mul_out.ready absorbed, next request gives a correct result.
//  mul_out.ready tied 0 -> err pulses at TIMEOUT+2 cycles after accept, FSM back in IDLE; reset asserted mid-BUSY -> all outputs at reset values immediately.
//  MUL_REUSE_EN: mulh a,b twice -> second gives res_valid 1 cycle after accept, enable count=1; flush between -> enable count=2.

Source files
------------

// File: rtl/mul_ctrl_pkg.sv
// Shared types for the multiply issue/retire sequencer (mul_ctrl) and the
// mul unit it feeds.
//   mul_op_type          one-hot multiply opcode {muls, mulh, mulhsu, mulhu}
//   mul_in_type          controller -> mul: operands, opcode, enable pulse
//   mul_out_type         mul -> controller: result, ready
//   mul_ctrl_state_type  sequencer states
//   mul_ctrl_reg_type    sequencer register bundle; init_mul_ctrl_reg is its reset value
// Optional feature macro: MUL_REUSE_EN adds last-result cache fields to the
// register bundle.
package mul_ctrl_pkg;

    localparam int TIMEOUT_DEFAULT = 63;

    typedef struct packed {
        logic muls;
        logic mulh;
        logic mulhsu;
        logic mulhu;
    } mul_op_type;

    typedef struct packed {
        logic [31:0] rdata1;
        logic [31:0] rdata2;
        mul_op_type  op;
        logic        enable;
    } mul_in_type;

    typedef struct packed {
        logic [31:0] result;
        logic        ready;
    } mul_out_type;

    // IDLE must stay at encoding 0 so an all-zero register bundle is the reset state.
    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LAUNCH = 3'd1,
        BUSY   = 3'd2,
        FULL   = 3'd3,
        DRAIN  = 3'd4
    } mul_ctrl_state_type;

    typedef struct packed {
        mul_ctrl_state_type state;
        logic [31:0]        rdata1;
        logic [31:0]        rdata2;
        mul_op_type         op;
        logic [4:0]         waddr;
        logic [31:0]        res_data;
        logic               err;
`ifdef MUL_REUSE_EN
        logic [31:0]        c_rdata1;
        logic [31:0]        c_rdata2;
        mul_op_type         c_op;
        logic [31:0]        c_result;
        logic               cvalid;
`endif
    } mul_ctrl_reg_type;

    localparam mul_ctrl_reg_type init_mul_ctrl_reg = '0;

endpackage

// File: rtl/mul_ctrl.sv
// mul_ctrl: issue/retire sequencer sitting directly upstream of mul.
// Accepts a multiply request, registers operands, pulses mul_in.enable for
// one cycle, holds operands until mul_out.ready, then holds the result in a
// one-entry buffer until writeback takes it. Works with a combinational-ready
// (single-cycle) mul or a 33-cycle serial mul.
// Ports:
//   clock, reset              system clock, async active-high reset
//   req_valid/req_ready       request handshake; req_rdata1/2, req_op, req_waddr
//   flush                     squash the in-flight op
//   mul_in / mul_out          interface to mul
//   res_valid/res_ready       result handshake; res_data, res_waddr
//   err                       one-cycle pulse when mul fails to answer in TIMEOUT cycles
// Optional feature macro: MUL_REUSE_EN (last-result cache, skips mul on exact repeat).
//
// state  | meaning
// IDLE   | waiting for a request
// LAUNCH | operands presented, enable pulsed this cycle
// BUSY   | waiting for mul_out.ready, operands held
// FULL   | result buffered, waiting for writeback
// DRAIN  | op squashed, waiting for mul to finish so it is never re-enabled mid-op
module mul_ctrl
    import mul_ctrl_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic [31:0] req_rdata1,
    input  logic [31:0] req_rdata2,
    input  mul_op_type  req_op,
    input  logic [4:0]  req_waddr,
    input  logic        flush,
    output mul_in_type  mul_in,
    input  mul_out_type mul_out,
    output logic        res_valid,
    input  logic        res_ready,
    output logic [31:0] res_data,
    output logic [4:0]  res_waddr,
    output logic        err
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] TO_VAL = CNT_W'(TIMEOUT);

    mul_ctrl_reg_type r_q, r_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [CNT_W-1:0] cnt_inc;

    assign cnt_inc = cnt_q + CNT_W'(1);

`ifdef MUL_REUSE_EN
    logic hit;
    assign hit = r_q.cvalid
              && (req_rdata1 == r_q.c_rdata1)
              && (req_rdata2 == r_q.c_rdata2)
              && (req_op == r_q.c_op);
`endif

    always_comb begin
        r_d     = r_q;
        cnt_d   = cnt_q;
        r_d.err = 1'b0;
`ifdef MUL_REUSE_EN
        if (flush) begin
            r_d.cvalid = 1'b0;
        end
`endif
        case (r_q.state)
            IDLE: begin
                if (req_valid && !flush) begin
                    r_d.rdata1 = req_rdata1;
                    r_d.rdata2 = req_rdata2;
                    r_d.op     = req_op;
                    r_d.waddr  = req_waddr;
`ifdef MUL_REUSE_EN
                    if (hit) begin
                        r_d.res_data = r_q.c_result;
                        r_d.state    = FULL;
                    end else begin
                        r_d.state = LAUNCH;
                        cnt_d     = '0;
                    end
`else
                    r_d.state = LAUNCH;
                    cnt_d     = '0;
`endif
                end
            end
            LAUNCH, BUSY: begin
                if (mul_out.ready) begin
                    if (flush) begin
                        r_d.state = IDLE;
                    end else begin
                        r_d.res_data = mul_out.result;
                        r_d.state    = FULL;
`ifdef MUL_REUSE_EN
                        r_d.c_rdata1 = r_q.rdata1;
                        r_d.c_rdata2 = r_q.rdata2;
                        r_d.c_op     = r_q.op;
                        r_d.c_result = mul_out.result;
                        r_d.cvalid   = 1'b1;
`endif
                    end
                end else if (flush) begin
                    r_d.state = DRAIN;
                    cnt_d     = '0;
                end else if (r_q.state == LAUNCH) begin
                    r_d.state = BUSY;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO_VAL) begin
                        r_d.err   = 1'b1;
                        r_d.state = IDLE;
                    end
                end
            end
            FULL: begin
                // flush and res_ready both retire the buffer; writeback must
                // ignore the handshake when it is flushing.
                if (flush || res_ready) begin
                    r_d.state = IDLE;
                end
            end
            DRAIN: begin
                if (mul_out.ready) begin
                    r_d.state = IDLE;
                end else begin
                    cnt_d = cnt_inc;
                    if (cnt_inc == TO_VAL) begin
                        r_d.err   = 1'b1;
                        r_d.state = IDLE;
                    end
                end
            end
            default: begin
                r_d.state = IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_q   <= init_mul_ctrl_reg;
            cnt_q <= '0;
        end else begin
            r_q   <= r_d;
            cnt_q <= cnt_d;
        end
    end

    assign req_ready     = (r_q.state == IDLE) && !flush;
    assign res_valid     = (r_q.state == FULL);
    assign res_data      = r_q.res_data;
    assign res_waddr     = r_q.waddr;
    assign err           = r_q.err;
    assign mul_in.rdata1 = r_q.rdata1;
    assign mul_in.rdata2 = r_q.rdata2;
    assign mul_in.op     = r_q.op;
    assign mul_in.enable = (r_q.state == LAUNCH);

endmodule
